matrix_result_sender: RTL and testbench

- Transmit-side counterpart of the matrix loader: frames the product matrix C and streams it out byte-by-byte through the existing uartTX instance.
- Reads C row-major from the loader's internal result memory over a 1-cycle-latency read port.
- Emits a fixed frame: header, dimensions, big-endian elements, XOR checksum.
- Sits between the multiplication FSM (issues start) and uartTX (consumes tx_data/tx_start, reports tx_busy).

---
 rtl/matrix_result_sender_pkg.sv | 33 +++
 rtl/matrix_result_sender_if.sv | 22 ++
 rtl/matrix_result_sender_tx_byte_issuer.sv | 47 ++++
 rtl/matrix_result_sender.sv | 145 ++++++++++++++
 tb/tb_matrix_result_sender.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_result_sender_pkg.sv
// rtl/matrix_result_sender_pkg.sv - shared constants and state encodings for the result sender
//
// Purpose: frame header, default geometry and FSM state encodings shared by
//          the result sender top, its byte issuer and the bus interface.
// Ports:   none (package).
package matrix_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  localparam int DEF_MAX_M  = 4;
  localparam int DEF_MAX_P  = 4;
  localparam int DEF_DATA_W = 16;

  // Framing FSM states.
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE  = 4'd0;
  localparam state_t ST_HDR   = 4'd1;
  localparam state_t ST_DIM_M = 4'd2;
  localparam state_t ST_DIM_P = 4'd3;
  localparam state_t ST_FETCH = 4'd4;
  localparam state_t ST_CAPT  = 4'd5;
  localparam state_t ST_BYTE  = 4'd6;
  localparam state_t ST_CHK   = 4'd7;
  localparam state_t ST_DONE  = 4'd8;

  // Per-byte transmit handshake states.
  typedef logic [1:0] tx_state_t;
  localparam tx_state_t TX_LOAD  = 2'd0;
  localparam tx_state_t TX_ISSUE = 2'd1;
  localparam tx_state_t TX_GUARD = 2'd2;
  localparam tx_state_t TX_DRAIN = 2'd3;

endpackage

// File: rtl/matrix_result_sender_if.sv
// rtl/matrix_result_sender_if.sv - result-memory read port and uartTX byte port bundle
//
// Purpose: groups the result-memory read port and the uartTX byte port.
// Signals: rd_en/rd_addr -> memory, rd_data <- memory (1-cycle latency);
//          tx_data/tx_start -> uartTX, tx_busy <- uartTX.
// Modports: master = result sender side, slave = memory + uartTX side.
interface matrix_result_sender_if
  import matrix_pkg::*;
#(
  parameter int ADDR_W = $clog2(DEF_MAX_M * DEF_MAX_P),
  parameter int DATA_W = DEF_DATA_W
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;

  modport master (output rd_en, rd_addr, tx_data, tx_start, input rd_data, tx_busy);
  modport slave  (input rd_en, rd_addr, tx_data, tx_start, output rd_data, tx_busy);
endinterface

// File: rtl/matrix_result_sender_tx_byte_issuer.sv
// rtl/matrix_result_sender_tx_byte_issuer.sv - one-byte LOAD/ISSUE/GUARD/DRAIN handshake to uartTX
//
// Purpose: hands a single byte to uartTX with exactly one tx_start per byte.
// Ports:   clk, rst_n       clock, synchronous active-low reset
//          byte_valid/in    byte offered by the framer (sampled in LOAD)
//          byte_ack         1-cycle pulse when uartTX has finished the byte
//          tx_data/tx_start byte and start pulse to uartTX
//          tx_busy          uartTX busy
module tx_byte_issuer
  import matrix_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       byte_ack,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy
);

  tx_state_t st;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= TX_LOAD;
      tx_data <= 8'h00;
    end else begin
      case (st)
        // tx_data is only written here, so it stays put until DRAIN exits.
        TX_LOAD:  if (byte_valid) begin
                    tx_data <= byte_in;
                    st      <= TX_ISSUE;
                  end
        TX_ISSUE: if (!tx_busy) st <= TX_GUARD;
        // uartTX raises busy one cycle after it samples tx_start; skip that cycle.
        TX_GUARD: st <= TX_DRAIN;
        TX_DRAIN: if (!tx_busy) st <= TX_LOAD;
        default:  st <= TX_LOAD;
      endcase
    end
  end

  assign tx_start = (st == TX_ISSUE) && !tx_busy;
  assign byte_ack = (st == TX_DRAIN) && !tx_busy;

endmodule

// File: rtl/matrix_result_sender.sv
// rtl/matrix_result_sender.sv - frames product matrix C and streams it to uartTX
//
// Purpose: sends 0xA5, M, P, C row-major (DATA_W/8 bytes each, MSB first)
//          and an XOR checksum over M..last data byte.
// Ports:   clk, rst_n    clock, synchronous active-low reset
//          start         request; m_dim/p_dim sampled with it when idle
//          busy          high from accepted start until done
//          done          1-cycle pulse after the checksum byte completes
//          err           1-cycle pulse on a start with out-of-range dims
//          bus           result-memory read port and uartTX byte port
module matrix_result_sender
  import matrix_pkg::*;
#(
  parameter int MAX_M  = DEF_MAX_M,
  parameter int MAX_P  = DEF_MAX_P,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = $clog2(MAX_M * MAX_P)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] m_dim,
  input  logic [7:0] p_dim,
  output logic       busy,
  output logic       done,
  output logic       err,
  matrix_result_sender_if.master bus
);

  localparam int         NB     = DATA_W / 8;
  localparam logic [7:0] MAX_M8 = 8'(MAX_M);
  localparam logic [7:0] MAX_P8 = 8'(MAX_P);
  localparam logic [7:0] LAST_B = 8'(NB - 1);

  state_t            state;
  logic [7:0]        m_lat, p_lat, row, col, byte_idx, chk;
  logic [DATA_W-1:0] sreg;
  logic              byte_valid, byte_ack;
  logic [7:0]        byte_in;
  logic              dims_ok, last_col, last_elem;

  assign dims_ok   = (m_dim != 8'd0) && (m_dim <= MAX_M8) &&
                     (p_dim != 8'd0) && (p_dim <= MAX_P8);
  assign last_col  = (col == p_lat - 8'd1);
  assign last_elem = last_col && (row == m_lat - 8'd1);

  assign busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign done       = (state == ST_DONE);
  assign bus.rd_en  = (state == ST_FETCH);
  assign bus.rd_addr = ADDR_W'(int'(row) * MAX_P + int'(col));

  assign byte_valid = (state == ST_HDR) || (state == ST_DIM_M) || (state == ST_DIM_P) ||
                      (state == ST_BYTE) || (state == ST_CHK);

  // The element shifts left after each byte, so the current byte is always on top.
  always_comb begin
    byte_in = FRAME_HDR;
    case (state)
      ST_DIM_M: byte_in = m_lat;
      ST_DIM_P: byte_in = p_lat;
      ST_BYTE:  byte_in = sreg[DATA_W-1 -: 8];
      ST_CHK:   byte_in = chk;
      default:  byte_in = FRAME_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      m_lat    <= 8'd0;
      p_lat    <= 8'd0;
      row      <= 8'd0;
      col      <= 8'd0;
      byte_idx <= 8'd0;
      chk      <= 8'd0;
      sreg     <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
                   if (dims_ok) begin
                     m_lat <= m_dim;
                     p_lat <= p_dim;
                     row   <= 8'd0;
                     col   <= 8'd0;
                     chk   <= 8'd0;
                     state <= ST_HDR;
                   end else begin
                     err <= 1'b1;
                   end
                 end
        ST_HDR:   if (byte_ack) state <= ST_DIM_M;
        ST_DIM_M: if (byte_ack) begin
                    chk   <= chk ^ m_lat;
                    state <= ST_DIM_P;
                  end
        ST_DIM_P: if (byte_ack) begin
                    chk   <= chk ^ p_lat;
                    state <= ST_FETCH;
                  end
        ST_FETCH: state <= ST_CAPT;
        ST_CAPT: begin
                   sreg     <= bus.rd_data;
                   byte_idx <= 8'd0;
                   state    <= ST_BYTE;
                 end
        ST_BYTE: if (byte_ack) begin
                   chk  <= chk ^ sreg[DATA_W-1 -: 8];
                   sreg <= sreg << 8;
                   if (byte_idx == LAST_B) begin
                     if (last_elem) begin
                       state <= ST_CHK;
                     end else begin
                       state <= ST_FETCH;
                       if (last_col) begin
                         col <= 8'd0;
                         row <= row + 8'd1;
                       end else begin
                         col <= col + 8'd1;
                       end
                     end
                   end else begin
                     byte_idx <= byte_idx + 8'd1;
                   end
                 end
        ST_CHK:  if (byte_ack) state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  tx_byte_issuer u_issuer (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .byte_ack   (byte_ack),
    .tx_data    (bus.tx_data),
    .tx_start   (bus.tx_start),
    .tx_busy    (bus.tx_busy)
  );

endmodule

// File: tb/tb_matrix_result_sender.sv
// tb/tb_matrix_result_sender.sv - scoreboard bench for matrix_result_sender
module tb_matrix_result_sender;
  import matrix_pkg::*;

  localparam int MM = 4;
  localparam int MP = 4;
  localparam int DW = 16;
  localparam int AW = $clog2(MM * MP);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] m_dim = 8'd0;
  logic [7:0] p_dim = 8'd0;
  logic       busy, done, err;

  matrix_result_sender_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  matrix_result_sender #(.MAX_M(MM), .MAX_P(MP), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .m_dim (m_dim),
    .p_dim (p_dim),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Result memory with one-cycle read latency.
  logic [DW-1:0] mem [0:15];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  // uartTX model: busy for a fixed or random number of cycles per byte.
  int busy_cnt = 0;
  int stall_mode = 0;
  always @(posedge clk) begin
    if (bus.tx_start) busy_cnt <= (stall_mode != 0) ? int'($urandom_range(200, 1)) : 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (busy_cnt != 0);

  // Output monitor, sampled on the falling edge.
  logic [7:0] rx_byte [256];
  int         addr_log [64];
  int         rx_n = 0, addr_n = 0, done_cnt = 0, err_cnt = 0;
  int         viol_busy = 0, viol_data = 0, viol_done = 0;
  logic [7:0] last_tx = 8'h00;
  bit         armed = 1'b0;

  always @(negedge clk) begin
    if (bus.tx_start) begin
      rx_byte[rx_n[7:0]] <= bus.tx_data;
      rx_n    <= rx_n + 1;
      last_tx <= bus.tx_data;
      armed   <= 1'b1;
      if (bus.tx_busy) viol_busy <= viol_busy + 1;
    end else if (!rst_n) begin
      armed <= 1'b0;
    end else if (armed && bus.tx_busy && bus.tx_data !== last_tx) begin
      viol_data <= viol_data + 1;
    end
    if (bus.rd_en) begin
      addr_log[addr_n[5:0]] <= int'(bus.rd_addr);
      addr_n <= addr_n + 1;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      if (busy) viol_done <= viol_done + 1;
    end
    if (err) err_cnt <= err_cnt + 1;
  end

  int         total = 0, bad = 0;
  logic [7:0] exp_q [$];
  int         exp_a [$];

  // Scoreboard feed: the full expected frame and read-address sequence.
  task automatic push_frame(input int m, input int p);
    logic [7:0]    chk;
    logic [7:0]    b;
    logic [DW-1:0] w;
    chk = m[7:0] ^ p[7:0];
    exp_q.push_back(8'hA5);
    exp_q.push_back(m[7:0]);
    exp_q.push_back(p[7:0]);
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < p; c++) begin
        exp_a.push_back(r * MP + c);
        w = mem[r * MP + c];
        for (int k = DW / 8 - 1; k >= 0; k--) begin
          b = w[8 * k +: 8];
          exp_q.push_back(b);
          chk = chk ^ b;
        end
      end
    end
    exp_q.push_back(chk);
  endtask

  task automatic start_frame(input int m, input int p);
    @(posedge clk); #1;
    m_dim = m[7:0];
    p_dim = p[7:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", bus.rd_en); end
    total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b want=0", bus.tx_start); end
    total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", bus.tx_data); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_2x2();
    int r0, a0, d0, v0;
    bit ok;
    logic [7:0] e;
    mem[0] = 16'h0001; mem[1] = 16'h0002; mem[4] = 16'h0003; mem[5] = 16'h0004;
    push_frame(2, 2);
    r0 = rx_n; a0 = addr_n; d0 = done_cnt; v0 = viol_busy + viol_data + viol_done;
    start_frame(2, 2);
    total++; if (busy !== 1'b1 || bus.tx_start !== 1'b0) begin bad++; $display("FAIL 2x2_accept busy=%b tx_start=%b want busy=1 tx_start=0", busy, bus.tx_start); end
    @(posedge clk); #1;
    total++; if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hA5) begin bad++; $display("FAIL 2x2_hdr_latency tx_start=%b data=%h want 1/a5", bus.tx_start, bus.tx_data); end
    wait_done(d0, 5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL 2x2_timeout got=no_done want=done"); end
    total++; if (rx_n - r0 != exp_q.size()) begin bad++; $display("FAIL 2x2_count got=%0d want=%0d", rx_n - r0, exp_q.size()); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++; if (rx_byte[r0[7:0]] !== e) begin bad++; $display("FAIL 2x2_byte got=%h want=%h", rx_byte[r0[7:0]], e); end
      r0++;
    end
    while (exp_a.size() != 0) begin
      total++; if (addr_log[a0[5:0]] != exp_a[0]) begin bad++; $display("FAIL 2x2_addr got=%0d want=%0d", addr_log[a0[5:0]], exp_a[0]); end
      void'(exp_a.pop_front());
      a0++;
    end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL 2x2_done got=%0d want=1", done_cnt - d0); end
    total++; if (viol_busy + viol_data + viol_done - v0 != 0) begin bad++; $display("FAIL 2x2_protocol got=%0d want=0", viol_busy + viol_data + viol_done - v0); end
  endtask

  task automatic test_1x1();
    int r0, d0;
    bit ok;
    logic [7:0] e;
    mem[0] = 16'hBEEF;
    push_frame(1, 1);
    r0 = rx_n; d0 = done_cnt;
    start_frame(1, 1);
    wait_done(d0, 5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL 1x1_timeout got=no_done want=done"); end
    total++; if (rx_n - r0 != 6) begin bad++; $display("FAIL 1x1_tx_starts got=%0d want=6", rx_n - r0); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++; if (rx_byte[r0[7:0]] !== e) begin bad++; $display("FAIL 1x1_byte got=%h want=%h", rx_byte[r0[7:0]], e); end
      r0++;
    end
    exp_a.delete();
  endtask

  task automatic test_reject();
    int r0, e0;
    r0 = rx_n; e0 = err_cnt;
    start_frame(0, 2);
    total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rej_m0 err=%b busy=%b want 1/0", err, busy); end
    @(posedge clk); #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rej_err_width got=%b want=0", err); end
    start_frame(2, 5);
    total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rej_p5 err=%b busy=%b want 1/0", err, busy); end
    repeat (20) @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rej_busy got=%b want=0", busy); end
    total++; if (err_cnt - e0 != 2) begin bad++; $display("FAIL rej_err_count got=%0d want=2", err_cnt - e0); end
    total++; if (rx_n - r0 != 0) begin bad++; $display("FAIL rej_tx_start got=%0d want=0", rx_n - r0); end
  endtask

  task automatic test_full_4x4();
    int r0, a0, d0, e0;
    bit ok;
    logic [7:0] e;
    for (int i = 0; i < 16; i++) mem[i] = DW'(i);
    push_frame(4, 4);
    total++; if (exp_q[exp_q.size() - 1] !== 8'h00) begin bad++; $display("FAIL 4x4_model_chk got=%h want=00", exp_q[exp_q.size() - 1]); end
    r0 = rx_n; a0 = addr_n; d0 = done_cnt; e0 = err_cnt;
    start_frame(4, 4);
    repeat (40) @(posedge clk);
    start_frame(2, 2);
    wait_done(d0, 10000, ok);
    total++; if (!ok) begin bad++; $display("FAIL 4x4_timeout got=no_done want=done"); end
    total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL 4x4_mid_start_err got=%0d want=0", err_cnt - e0); end
    total++; if (rx_n - r0 != 36) begin bad++; $display("FAIL 4x4_count got=%0d want=36", rx_n - r0); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++; if (rx_byte[r0[7:0]] !== e) begin bad++; $display("FAIL 4x4_byte got=%h want=%h", rx_byte[r0[7:0]], e); end
      r0++;
    end
    while (exp_a.size() != 0) begin
      total++; if (addr_log[a0[5:0]] != exp_a[0]) begin bad++; $display("FAIL 4x4_addr got=%0d want=%0d", addr_log[a0[5:0]], exp_a[0]); end
      void'(exp_a.pop_front());
      a0++;
    end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL 4x4_done got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_stall();
    int r0, d0, v0;
    bit ok;
    logic [7:0] e;
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
    stall_mode = 1;
    push_frame(3, 4);
    r0 = rx_n; d0 = done_cnt; v0 = viol_busy + viol_data + viol_done;
    start_frame(3, 4);
    wait_done(d0, 20000, ok);
    stall_mode = 0;
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout got=no_done want=done"); end
    total++; if (rx_n - r0 != exp_q.size()) begin bad++; $display("FAIL stall_count got=%0d want=%0d", rx_n - r0, exp_q.size()); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++; if (rx_byte[r0[7:0]] !== e) begin bad++; $display("FAIL stall_byte got=%h want=%h", rx_byte[r0[7:0]], e); end
      r0++;
    end
    exp_a.delete();
    total++; if (viol_busy + viol_data + viol_done - v0 != 0) begin bad++; $display("FAIL stall_protocol got=%0d want=0", viol_busy + viol_data + viol_done - v0); end
  endtask

  task automatic test_reset_mid();
    int r0, a0, d0;
    bit ok;
    logic [7:0] e;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[4] = 16'h3333; mem[5] = 16'h4444;
    a0 = addr_n;
    start_frame(2, 2);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (addr_n - a0 >= 2) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL rstmid_reach got=no_elem2 want=elem2"); end
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if ({busy, done, err, bus.rd_en, bus.tx_start} !== 5'b0) begin bad++; $display("FAIL rstmid_ctrl got=%b want=00000", {busy, done, err, bus.rd_en, bus.tx_start}); end
    total++; if (bus.tx_data !== 8'h00 || bus.rd_addr !== '0) begin bad++; $display("FAIL rstmid_data got=%h/%h want=00/0", bus.tx_data, bus.rd_addr); end
    rst_n = 1'b1;
    mem[0] = 16'hCAFE; mem[1] = 16'h0102; mem[4] = 16'hFF00; mem[5] = 16'h8001;
    push_frame(2, 2);
    exp_a.delete();
    r0 = rx_n; d0 = done_cnt;
    start_frame(2, 2);
    wait_done(d0, 5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout got=no_done want=done"); end
    total++; if (rx_n - r0 != exp_q.size()) begin bad++; $display("FAIL rstmid_count got=%0d want=%0d", rx_n - r0, exp_q.size()); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++; if (rx_byte[r0[7:0]] !== e) begin bad++; $display("FAIL rstmid_byte got=%h want=%h", rx_byte[r0[7:0]], e); end
      r0++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_2x2();
    test_1x1();
    test_reject();
    test_full_4x4();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
